avalon_mm_slave_regfile: RTL and testbench

Avalon-MM responder holding NUM_REGS 32-bit registers, and the slave-side counterpart of the team's Avalon-MM master. It accepts single-word reads and writes with per-byte enables. It inserts a programmable number of wait states via WAITREQUEST and returns read data one cycle after acceptance with READDATAVALID. Register contents and per-register write strobes are exported to user logic.

---
 rtl/avalon_mm_slave_regfile.sv | 114 +++++++++++
 tb/tb_avalon_mm_slave_regfile.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_slave_regfile.sv
// Avalon-MM responder holding NUM_REGS 32-bit byte-writable registers.
// Inserts WAIT_STATES wait cycles per transfer; read data is returned one cycle after acceptance.
module avalon_mm_slave_regfile #(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              ADDRESS,
    input  logic [3:0]               BYTE_ENABLE,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [31:0]              WRITEDATA,
    output logic [31:0]              READDATA,
    output logic                     WAITREQUEST,
    output logic                     READDATAVALID,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      write_pulse
);

    localparam int         AW = $clog2(NUM_REGS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic                req;
    logic                accept;
    logic                in_range;
    logic                wr_accept;
    logic                rd_accept;
    logic [AW-1:0]       index;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [NUM_REGS-1:0] wpulse_q, wpulse_d;
    logic [31:0]         regs_w [NUM_REGS];

    // Out-of-range covers both high address bits and misaligned byte offsets.
    always_comb begin
        req         = READ | WRITE;
        WAITREQUEST = RESET | (req & (wcnt_q != WS));
        accept      = req & ~WAITREQUEST;
        index       = ADDRESS[AW+1:2];
        in_range    = (ADDRESS[31:AW+2] == '0) && (ADDRESS[1:0] == 2'b00);
        wr_accept   = accept & WRITE & in_range;
        rd_accept   = accept & READ & ~WRITE;
    end

    // An abandoned request (req dropping before accept) restarts the count from zero.
    always_comb begin
        wcnt_d = wcnt_q + 4'd1;
        if (accept || !req) begin
            wcnt_d = 4'd0;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_accept;
        if (rd_accept) begin
            rdata_d = in_range ? regs_w[index] : 32'h0000_0000;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wcnt_q   <= 4'd0;
            rdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
            wpulse_q <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wpulse_q <= wpulse_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic        sel;
            logic [31:0] r_q, r_d;

            // A zero byte-enable write still counts as a write and pulses.
            assign sel          = wr_accept && (index == IDX);
            assign wpulse_d[gi] = sel;

            always_comb begin
                r_d = r_q;
                for (int li = 0; li < 4; li++) begin
                    if (sel && BYTE_ENABLE[li]) begin
                        r_d[8*li +: 8] = WRITEDATA[8*li +: 8];
                    end
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_q <= 32'h0000_0000;
                end else begin
                    r_q <= r_d;
                end
            end

            assign regs_w[gi]         = r_q;
            assign reg_q[32*gi +: 32] = r_q;
        end
    endgenerate

    assign READDATA      = rdata_q;
    assign READDATAVALID = rvalid_q;
    assign write_pulse   = wpulse_q;

endmodule

// File: tb/tb_avalon_mm_slave_regfile.sv
// Directed bench for avalon_mm_slave_regfile: one instance with two wait states, one with none.
`define CHK(tag, o, e) chk(tag, 256'(o), 256'(e))

module tb_avalon_mm_slave_regfile;

    logic clk;
    logic rst;

    logic [31:0]  addr2, wd2, rdata2;
    logic [3:0]   be2;
    logic         rd2, wr2, wreq2, rvalid2;
    logic [255:0] regq2;
    logic [7:0]   wp2;

    logic [31:0]  addr0, wd0, rdata0;
    logic [3:0]   be0;
    logic         rd0, wr0, wreq0, rvalid0;
    logic [255:0] regq0;
    logic [7:0]   wp0;

    int vectors    = 0;
    int miscompares = 0;
    int w;
    logic [255:0] exp_regs;

    avalon_mm_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(2)) dut2 (
        .CLK(clk), .RESET(rst), .ADDRESS(addr2), .BYTE_ENABLE(be2),
        .READ(rd2), .WRITE(wr2), .WRITEDATA(wd2), .READDATA(rdata2),
        .WAITREQUEST(wreq2), .READDATAVALID(rvalid2), .reg_q(regq2),
        .write_pulse(wp2)
    );

    avalon_mm_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RESET(rst), .ADDRESS(addr0), .BYTE_ENABLE(be0),
        .READ(rd0), .WRITE(wr0), .WRITEDATA(wd0), .READDATA(rdata0),
        .WAITREQUEST(wreq0), .READDATAVALID(rvalid0), .reg_q(regq0),
        .write_pulse(wp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer2(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data, output int waits);
        addr2 = addr;
        be2   = be;
        wd2   = data;
        rd2   = rd;
        wr2   = wr;
        #1;
        waits = 0;
        while (wreq2 === 1'b1 && waits < 20) begin
            @(posedge clk);
            #2;
            waits++;
        end
        @(posedge clk);
        #1;
        rd2 = 1'b0;
        wr2 = 1'b0;
        $display("xfer rd=%0b wr=%0b addr=%h be=%h data=%h waits=%0d", rd, wr, addr, be, data, waits);
    endtask

    initial begin
        rst = 1'b0;
        addr2 = '0; be2 = '0; rd2 = 1'b0; wr2 = 1'b0; wd2 = '0;
        addr0 = '0; be0 = '0; rd0 = 1'b0; wr0 = 1'b0; wd0 = '0;

        #3 rst = 1'b1;
        #1;
        `CHK("rst_readdata", rdata2, 32'h0);
        `CHK("rst_rvalid", rvalid2, 1'b0);
        `CHK("rst_waitreq", wreq2, 1'b1);
        `CHK("rst_regq", regq2, 256'h0);
        `CHK("rst_wpulse", wp2, 8'h00);
        `CHK("rst_waitreq0", wreq0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        `CHK("idle_waitreq", wreq2, 1'b0);
        `CHK("idle_waitreq0", wreq0, 1'b0);

        xfer2(1'b0, 1'b1, 32'h8, 4'hF, 32'hCAFE_F00D, w);
        vectors++;
        if (w != 2) begin
            miscompares++;
            $error("FAIL ws2_write_waits observed=%0d expected=2", w);
        end
        vectors++;
        if (regq2[95:64] !== 32'hCAFE_F00D) begin
            miscompares++;
            $error("FAIL reg2_value observed=%h expected=cafef00d", regq2[95:64]);
        end
        `CHK("reg2_pulse", wp2, 8'h04);
        tick;
        `CHK("reg2_pulse_end", wp2, 8'h00);

        xfer2(1'b0, 1'b1, 32'h4, 4'hF, 32'h1122_3344, w);
        xfer2(1'b0, 1'b1, 32'h4, 4'b0101, 32'hAABB_CCDD, w);
        vectors++;
        if (regq2[63:32] !== 32'h11BB_33DD) begin
            miscompares++;
            $error("FAIL lane_merge observed=%h expected=11bb33dd", regq2[63:32]);
        end
        `CHK("lane_pulse", wp2, 8'h02);
        xfer2(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, w);
        vectors++;
        if (w != 2) begin
            miscompares++;
            $error("FAIL read_waits observed=%0d expected=2", w);
        end
        `CHK("read_rvalid", rvalid2, 1'b1);
        vectors++;
        if (rdata2 !== 32'h11BB_33DD) begin
            miscompares++;
            $error("FAIL read_data observed=%h expected=11bb33dd", rdata2);
        end
        tick;
        `CHK("read_rvalid_end", rvalid2, 1'b0);
        `CHK("read_data_hold", rdata2, 32'h11BB_33DD);

        xfer2(1'b0, 1'b1, 32'h1C, 4'hF, 32'hDEAD_BEEF, w);
        `CHK("reg7_value", regq2[255:224], 32'hDEAD_BEEF);
        `CHK("reg7_pulse", wp2, 8'h80);

        exp_regs = '0;
        exp_regs[255:224] = 32'hDEAD_BEEF;
        exp_regs[95:64]   = 32'hCAFE_F00D;
        exp_regs[63:32]   = 32'h11BB_33DD;
        xfer2(1'b0, 1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF, w);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (regq2[32*k +: 32] !== exp_regs[32*k +: 32]) begin
                miscompares++;
                $error("FAIL oor100_reg%0d observed=%h expected=%h", k, regq2[32*k +: 32], exp_regs[32*k +: 32]);
            end
        end
        `CHK("oor100_pulse", wp2, 8'h00);
        xfer2(1'b0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, w);
        `CHK("oor20_regs", regq2, exp_regs);
        `CHK("oor20_pulse", wp2, 8'h00);
        xfer2(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, w);
        `CHK("oor_read_rvalid", rvalid2, 1'b1);
        vectors++;
        if (rdata2 !== 32'h0) begin
            miscompares++;
            $error("FAIL oor_read_data observed=%h expected=0", rdata2);
        end
        xfer2(1'b1, 1'b0, 32'h1C, 4'h0, 32'h0, w);
        `CHK("reg7_read", rdata2, 32'hDEAD_BEEF);
        xfer2(1'b1, 1'b0, 32'h9, 4'h0, 32'h0, w);
        `CHK("misalign_rvalid", rvalid2, 1'b1);
        `CHK("misalign_data", rdata2, 32'h0);

        xfer2(1'b1, 1'b1, 32'h0, 4'hF, 32'h1234_5678, w);
        `CHK("both_rvalid", rvalid2, 1'b0);
        `CHK("both_reg0", regq2[31:0], 32'h1234_5678);
        `CHK("both_pulse", wp2, 8'h01);

        addr2 = 32'h4;
        rd2 = 1'b1;
        #1;
        `CHK("abort_waitreq", wreq2, 1'b1);
        tick;
        rd2 = 1'b0;
        tick;
        `CHK("abort_rvalid_a", rvalid2, 1'b0);
        tick;
        `CHK("abort_rvalid_b", rvalid2, 1'b0);
        xfer2(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, w);
        `CHK("abort_recount_waits", w, 2);
        `CHK("abort_reissue_data", rdata2, 32'h11BB_33DD);
        $display("abort read dropped after one wait cycle, reissue waits=%0d", w);

        addr0 = 32'hC;
        be0 = 4'hF;
        wd0 = 32'h5;
        wr0 = 1'b1;
        #1;
        `CHK("ws0_write_waitreq", wreq0, 1'b0);
        @(posedge clk);
        #1;
        wr0 = 1'b0;
        rd0 = 1'b1;
        `CHK("ws0_reg3", regq0[127:96], 32'h5);
        `CHK("ws0_pulse", wp0, 8'h08);
        #1;
        `CHK("ws0_read_waitreq", wreq0, 1'b0);
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        `CHK("ws0_rvalid", rvalid0, 1'b1);
        vectors++;
        if (rdata0 !== 32'h5) begin
            miscompares++;
            $error("FAIL ws0_rdata observed=%h expected=5", rdata0);
        end
        tick;
        `CHK("ws0_rvalid_end", rvalid0, 1'b0);
        $display("ws0 back-to-back write/read reg3 data=%h", rdata0);

        addr2 = 32'h4;
        rd2 = 1'b1;
        tick;
        tick;
        #1;
        `CHK("rstacc_pre_waitreq", wreq2, 1'b0);
        rst = 1'b1;
        #1;
        `CHK("rstacc_waitreq", wreq2, 1'b1);
        `CHK("rstacc_regs", regq2, 256'h0);
        `CHK("rstacc_rvalid_a", rvalid2, 1'b0);
        @(posedge clk);
        #1;
        `CHK("rstacc_rvalid_b", rvalid2, 1'b0);
        rst = 1'b0;
        rd2 = 1'b0;
        tick;
        `CHK("rstacc_rvalid_c", rvalid2, 1'b0);
        `CHK("rstacc_regs0", regq0, 256'h0);
        $display("reset during accept cycle, rvalid=%0b", rvalid2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
